// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - SPI mode-0 slave frame receiver with length, CRC-8 and CS-timeout checks
// Oversamples SCLK/CS/MOSI in the clk domain and publishes a whole frame as one wide word.
module spi_frame_rx #(
  parameter int FRAME_BYTES = 51,
  parameter int CRC_EN      = 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic                     MOSI,
  input  logic                     CS,
  input  logic                     SCLK,
  output logic [8*FRAME_BYTES-1:0] frame_data,
  output logic                     frame_wr,
  output logic                     crc_err,
  output logic                     len_err,
  output logic                     tmo_err,
  output logic                     busy,
  output logic [15:0]              frame_cnt
);

  localparam int FW     = 8 * FRAME_BYTES;
  localparam int BC_MAX = FRAME_BYTES + CRC_EN + 1;
  localparam int BC_W   = $clog2(BC_MAX + 1);

  localparam logic [BC_W-1:0] BC_PAY  = BC_W'(FRAME_BYTES);
  localparam logic [BC_W-1:0] BC_GOOD = BC_W'(FRAME_BYTES + CRC_EN);
  localparam logic [BC_W-1:0] BC_SAT  = BC_W'(BC_MAX);
  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_DRAIN = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_RECV  = 2'd2;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   cs_hist;
  logic                   sclk_hist;
  logic                   mosi_hist;
  logic                   cs_rise;
  logic                   cs_fall;
  logic                   sclk_rise;

  logic [1:0]      state;
  logic [2:0]      bit_cnt;
  logic [BC_W-1:0] byte_cnt;
  logic [7:0]      byte_sr;
  logic [7:0]      byte_nxt;
  logic [7:0]      crc;
  logic [FW-1:0]   shift_sr;
  logic [15:0]     tmo_cnt;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  // Edge flags are registered so that they line up with the history flops,
  // which then serve as the "synchronised level" seen together with each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_hist   <= 1'b0;
      sclk_hist <= 1'b0;
      mosi_hist <= 1'b0;
      cs_rise   <= 1'b0;
      cs_fall   <= 1'b0;
      sclk_rise <= 1'b0;
    end else if (clk_en) begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      cs_hist   <= cs_sync[SYNC_STAGES-1];
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      mosi_hist <= mosi_sync[SYNC_STAGES-1];
      cs_rise   <= cs_sync[SYNC_STAGES-1] & ~cs_hist;
      cs_fall   <= ~cs_sync[SYNC_STAGES-1] & cs_hist;
      sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_hist;
    end
  end

  assign byte_nxt = {byte_sr[6:0], mosi_hist};
  assign busy     = (state == ST_RECV);

  // Result pulses clear on every clock, independent of clk_en, so they never stretch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_DRAIN;
      bit_cnt    <= 3'd0;
      byte_cnt   <= '0;
      byte_sr    <= 8'h00;
      crc        <= 8'h00;
      shift_sr   <= '0;
      tmo_cnt    <= 16'd0;
      frame_data <= '0;
      frame_wr   <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      tmo_err    <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      frame_wr <= 1'b0;
      crc_err  <= 1'b0;
      len_err  <= 1'b0;
      tmo_err  <= 1'b0;
      if (clk_en) begin
        case (state)
          ST_DRAIN: begin
            if (cs_hist) state <= ST_IDLE;
          end
          ST_IDLE: begin
            if (cs_fall) begin
              bit_cnt  <= 3'd0;
              byte_cnt <= '0;
              crc      <= 8'h00;
              tmo_cnt  <= 16'd0;
              state    <= ST_RECV;
            end
          end
          ST_RECV: begin
            if (cs_rise) begin
              state <= ST_IDLE;
              if (bit_cnt != 3'd0 || byte_cnt != BC_GOOD) begin
                len_err <= 1'b1;
              end else if (CRC_EN != 0 && crc != 8'h00) begin
                crc_err <= 1'b1;
              end else begin
                frame_data <= shift_sr;
                frame_wr   <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
              end
            end else if (tmo_cnt == TMO_LAST) begin
              tmo_err <= 1'b1;
              state   <= ST_DRAIN;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
              if (sclk_rise && !cs_hist) begin
                byte_sr <= byte_nxt;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  // Overrun bytes still feed the CRC and the count but never the payload.
                  if (byte_cnt < BC_PAY) shift_sr <= (shift_sr << 8) | FW'(byte_nxt);
                  crc <= crc8_byte(crc, byte_nxt);
                  if (byte_cnt != BC_SAT) byte_cnt <= byte_cnt + BC_W'(1);
                end
              end
            end
          end
          default: state <= ST_DRAIN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb/tb_spi_frame_rx.sv - directed bench for spi_frame_rx with an expected-event scoreboard
// Two instances: default 51-byte CRC frames, and a 4-byte no-CRC build with clk_en toggling.
module tb_spi_frame_rx;

  typedef struct packed {
    logic [3:0]   kind;
    logic [407:0] data;
    logic [15:0]  cnt;
    logic [31:0]  cyc;
  } ev_t;

  localparam logic [3:0] K_WR  = 4'b0001;
  localparam logic [3:0] K_CRC = 4'b0010;
  localparam logic [3:0] K_LEN = 4'b0100;
  localparam logic [3:0] K_TMO = 4'b1000;

  logic clk;
  logic rst_n;
  logic clk_en1, mosi1, cs1, sclk1;
  logic clk_en2, mosi2, cs2, sclk2;
  logic [407:0] frame_data1;
  logic [31:0]  frame_data2;
  logic frame_wr1, crc_err1, len_err1, tmo_err1, busy1;
  logic frame_wr2, crc_err2, len_err2, tmo_err2, busy2;
  logic [15:0] frame_cnt1, frame_cnt2;

  int checks = 0;
  int errors = 0;
  bit tog2 = 1'b0;
  logic [31:0] cyc = 32'd0;
  int n_obs [2] = '{0, 0};
  int rd [2] = '{0, 0};
  ev_t obs0 [64];
  ev_t obs1 [64];
  ev_t exp0 [$];
  ev_t exp1 [$];

  logic [407:0] cur_frame;
  logic [7:0]   cur_crc;
  logic [407:0] g_data;
  logic [15:0]  g_cnt;
  logic [31:0]  t0;
  logic [31:0]  dt;
  ev_t          ev;

  spi_frame_rx dut1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en1), .MOSI(mosi1), .CS(cs1), .SCLK(sclk1),
    .frame_data(frame_data1), .frame_wr(frame_wr1), .crc_err(crc_err1), .len_err(len_err1),
    .tmo_err(tmo_err1), .busy(busy1), .frame_cnt(frame_cnt1)
  );

  spi_frame_rx #(.FRAME_BYTES(4), .CRC_EN(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en2), .MOSI(mosi2), .CS(cs2), .SCLK(sclk2),
    .frame_data(frame_data2), .frame_wr(frame_wr2), .crc_err(crc_err2), .len_err(len_err2),
    .tmo_err(tmo_err2), .busy(busy2), .frame_cnt(frame_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  always @(negedge clk) begin
    if ({tmo_err1, len_err1, crc_err1, frame_wr1} != 4'b0 && n_obs[0] < 64) begin
      obs0[n_obs[0][5:0]] <= {{tmo_err1, len_err1, crc_err1, frame_wr1}, frame_data1, frame_cnt1, cyc};
      n_obs[0] <= n_obs[0] + 1;
    end
    if ({tmo_err2, len_err2, crc_err2, frame_wr2} != 4'b0 && n_obs[1] < 64) begin
      obs1[n_obs[1][5:0]] <= {{tmo_err2, len_err2, crc_err2, frame_wr2}, 408'(frame_data2), frame_cnt2, cyc};
      n_obs[1] <= n_obs[1] + 1;
    end
  end

  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (tog2) clk_en2 = ~clk_en2;
    end
  endtask

  task automatic put_bit(input int d, input logic b, input int h);
    if (d == 0) begin mosi1 = b; sclk1 = 1'b0; end
    else begin mosi2 = b; sclk2 = 1'b0; end
    tick(h);
    if (d == 0) sclk1 = 1'b1; else sclk2 = 1'b1;
    tick(h);
  endtask

  task automatic put_byte(input int d, input logic [7:0] b, input int h);
    for (int i = 7; i >= 0; i--) put_bit(d, b[i], h);
  endtask

  task automatic cs_drop(input int d, input int h);
    if (d == 0) cs1 = 1'b0; else cs2 = 1'b0;
    cur_frame = '0;
    cur_crc = 8'h00;
    tick(h);
  endtask

  task automatic cs_raise(input int d, input int h, input int gap);
    if (d == 0) sclk1 = 1'b0; else sclk2 = 1'b0;
    tick(h);
    if (d == 0) cs1 = 1'b1; else cs2 = 1'b1;
    tick(gap);
  endtask

  task automatic payload(input int seed, input int from, input int upto, input int h);
    logic [7:0] b;
    for (int i = from; i < upto; i++) begin
      b = (i == 0) ? 8'h80 : 8'(i * seed);
      put_byte(0, b, h);
      cur_frame = {cur_frame[399:0], b};
      cur_crc = crc8_upd(cur_crc, b);
    end
  endtask

  task automatic push_exp(input int d, input logic [3:0] k, input logic [407:0] dat, input logic [15:0] c);
    ev_t e;
    e.kind = k;
    e.data = dat;
    e.cnt  = c;
    e.cyc  = 32'd0;
    if (d == 0) exp0.push_back(e); else exp1.push_back(e);
  endtask

  task automatic check_next(input int d, input string tag, input int bound, output ev_t o);
    ev_t e;
    int w;
    int qs;
    w = 0;
    o = '0;
    while (n_obs[d] <= rd[d] && w < bound) begin
      tick(1);
      w++;
    end
    qs = (d == 0) ? exp0.size() : exp1.size();
    checks++;
    assert (n_obs[d] > rd[d] && qs > 0) else begin
      errors++;
      $error("FAIL %s no event within %0d cycles (observed %0d expected-queue %0d)", tag, bound, n_obs[d] - rd[d], qs);
    end
    if (n_obs[d] > rd[d] && qs > 0) begin
      e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
      o = (d == 0) ? obs0[rd[d][5:0]] : obs1[rd[d][5:0]];
      rd[d]++;
      checks++;
      assert (o.kind === e.kind) else begin
        errors++;
        $error("FAIL %s_kind observed %b expected %b", tag, o.kind, e.kind);
      end
      checks++;
      assert (o.data === e.data) else begin
        errors++;
        $error("FAIL %s_data observed %h expected %h", tag, o.data, e.data);
      end
      checks++;
      assert (o.cnt === e.cnt) else begin
        errors++;
        $error("FAIL %s_cnt observed %0d expected %0d", tag, o.cnt, e.cnt);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clk_en1 = 1'b1; mosi1 = 1'b0; cs1 = 1'b1; sclk1 = 1'b0;
    clk_en2 = 1'b1; mosi2 = 1'b0; cs2 = 1'b1; sclk2 = 1'b0;
    g_data = '0;
    g_cnt = 16'd0;
    tick(5);

    checks++;
    assert (frame_data1 === 408'd0 && frame_cnt1 === 16'd0) else begin
      errors++; $error("FAIL reset_data1 observed %h/%0d expected 0/0", frame_data1, frame_cnt1);
    end
    checks++;
    assert ({busy1, frame_wr1, crc_err1, len_err1, tmo_err1} === 5'b0) else begin
      errors++; $error("FAIL reset_flags1 observed %b expected 00000", {busy1, frame_wr1, crc_err1, len_err1, tmo_err1});
    end
    checks++;
    assert (frame_data2 === 32'd0 && frame_cnt2 === 16'd0 && busy2 === 1'b0) else begin
      errors++; $error("FAIL reset_dut2 observed %h/%0d/%b expected 0/0/0", frame_data2, frame_cnt2, busy2);
    end
    rst_n = 1'b1;
    tick(10);

    // good 51-byte frame at clk/8
    cs_drop(0, 4);
    payload(1, 0, 51, 4);
    checks++;
    assert (busy1 === 1'b1) else begin errors++; $error("FAIL busy_mid observed %b expected 1", busy1); end
    put_byte(0, cur_crc, 4);
    g_data = cur_frame;
    g_cnt = 16'd1;
    push_exp(0, K_WR, g_data, g_cnt);
    cs_raise(0, 4, 12);
    check_next(0, "good1", 8000, ev);
    checks++;
    assert (frame_data1[407:400] === 8'h80) else begin
      errors++; $error("FAIL good1_msb observed %h expected 80", frame_data1[407:400]);
    end
    checks++;
    assert (busy1 === 1'b0) else begin errors++; $error("FAIL busy_after observed %b expected 0", busy1); end

    // bad CRC trailer
    cs_drop(0, 3);
    payload(2, 0, 51, 3);
    put_byte(0, cur_crc ^ 8'h01, 3);
    push_exp(0, K_CRC, g_data, g_cnt);
    cs_raise(0, 3, 12);
    check_next(0, "crcbad", 8000, ev);

    // one extra SCLK after the trailer
    cs_drop(0, 3);
    payload(1, 0, 51, 3);
    put_byte(0, cur_crc, 3);
    put_bit(0, 1'b0, 3);
    push_exp(0, K_LEN, g_data, g_cnt);
    cs_raise(0, 3, 12);
    check_next(0, "len409", 8000, ev);

    // missing trailer
    cs_drop(0, 3);
    payload(1, 0, 51, 3);
    push_exp(0, K_LEN, g_data, g_cnt);
    cs_raise(0, 3, 12);
    check_next(0, "len408", 8000, ev);

    // CS stuck low after 10 bytes
    t0 = cyc;
    cs_drop(0, 3);
    payload(7, 0, 10, 3);
    sclk1 = 1'b0;
    push_exp(0, K_TMO, g_data, g_cnt);
    check_next(0, "tmo", 70000, ev);
    dt = ev.cyc - t0;
    checks++;
    assert (dt >= 32'd65535 && dt <= 32'd65545) else begin
      errors++; $error("FAIL tmo_delay observed %0d expected 65535..65545", dt);
    end
    checks++;
    assert (busy1 === 1'b0) else begin errors++; $error("FAIL tmo_busy observed %b expected 0", busy1); end
    tick(100);
    cs1 = 1'b1;
    tick(12);

    cs_drop(0, 3);
    payload(3, 0, 51, 3);
    put_byte(0, cur_crc, 3);
    g_data = cur_frame;
    g_cnt = g_cnt + 16'd1;
    push_exp(0, K_WR, g_data, g_cnt);
    cs_raise(0, 3, 12);
    check_next(0, "after_tmo", 8000, ev);

    // reset in the middle of a frame, CS kept low to the end
    cs_drop(0, 3);
    payload(5, 0, 20, 3);
    rst_n = 1'b0;
    #1;
    checks++;
    assert (frame_data1 === 408'd0 && frame_cnt1 === 16'd0 && busy1 === 1'b0) else begin
      errors++; $error("FAIL midreset observed %h/%0d/%b expected 0/0/0", frame_data1, frame_cnt1, busy1);
    end
    tick(2);
    rst_n = 1'b1;
    payload(5, 20, 51, 3);
    put_byte(0, cur_crc, 3);
    cs_raise(0, 3, 12);
    g_data = '0;
    g_cnt = 16'd0;

    cs_drop(0, 3);
    payload(9, 0, 51, 3);
    put_byte(0, cur_crc, 3);
    g_data = cur_frame;
    g_cnt = 16'd1;
    push_exp(0, K_WR, g_data, g_cnt);
    cs_raise(0, 3, 12);
    check_next(0, "after_rst", 8000, ev);

    // 4-byte no-CRC build, back-to-back frames, clk_en toggling
    tog2 = 1'b1;
    tick(4);
    cs_drop(1, 8);
    put_byte(1, 8'hDE, 8); put_byte(1, 8'hAD, 8); put_byte(1, 8'hBE, 8); put_byte(1, 8'hEF, 8);
    push_exp(1, K_WR, 408'(32'hDEADBEEF), 16'd1);
    cs_raise(1, 8, 8);
    cs_drop(1, 8);
    put_byte(1, 8'h01, 8); put_byte(1, 8'h23, 8); put_byte(1, 8'h45, 8); put_byte(1, 8'h67, 8);
    push_exp(1, K_WR, 408'(32'h01234567), 16'd2);
    cs_raise(1, 8, 30);
    check_next(1, "b2b_1", 2000, ev);
    check_next(1, "b2b_2", 2000, ev);
    tog2 = 1'b0;
    clk_en2 = 1'b1;

    tick(20);
    checks++;
    assert (n_obs[0] == rd[0] && exp0.size() == 0) else begin
      errors++; $error("FAIL extra_events1 observed %0d expected %0d", n_obs[0], rd[0]);
    end
    checks++;
    assert (n_obs[1] == rd[1] && exp1.size() == 0) else begin
      errors++; $error("FAIL extra_events2 observed %0d expected %0d", n_obs[1], rd[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
